// File: rtl/texture_streamer.sv
// texture_streamer: streams a 32x32, 64x64 or 128x128 texture from a word-addressed RAM onto
// AXI-Stream through a 2-entry skid FIFO, sustaining one beat per clock while the sink is ready.
module texture_streamer #(
   parameter int STREAM_WIDTH = 16,
   parameter int SIZE = 15,
   localparam int ADDR_WIDTH = SIZE - $clog2(STREAM_WIDTH / 8)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [3:0]              mode,
   output logic                    busy,
   output logic                    done,
   output logic                    memReadEn,
   output logic [ADDR_WIDTH-1:0]   memReadAddr,
   input  logic [STREAM_WIDTH-1:0] memReadData,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic [STREAM_WIDTH-1:0] m_axis_tdata
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam int BEATS_32 = 1024 * 16 / STREAM_WIDTH;
   localparam int BEATS_64 = 4096 * 16 / STREAM_WIDTH;
   localparam int BEATS_128 = 16384 * 16 / STREAM_WIDTH;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  state_s;
   logic [CW-1:0]           beats_r;
   logic [CW-1:0]           rd_cnt_r;
   logic [CW-1:0]           out_cnt_r;
   logic                    rd_vld_r;
   logic [1:0]              occ_r;
   logic                    wr_ptr_r;
   logic                    rd_ptr_r;
   logic [STREAM_WIDTH-1:0] fifo_mem_r [2];
   logic                    done_r;

   logic                    mode_ok_s;
   logic [CW-1:0]           mode_beats_s;
   logic                    accept_s;
   logic                    pop_s;
   logic                    push_s;
   logic                    room_s;
   logic                    rd_en_s;
   logic                    last_rd_s;
   logic                    last_beat_s;

   function automatic logic [CW-1:0] beats_for(input logic [3:0] m);
      case (m)
         4'b0001: beats_for = CW'(BEATS_32);
         4'b0010: beats_for = CW'(BEATS_64);
         4'b0100: beats_for = CW'(BEATS_128);
         default: beats_for = {CW{1'b0}};
      endcase
   endfunction

   function automatic logic mode_valid(input logic [3:0] m);
      case (m)
         4'b0001: mode_valid = 1'b1;
         4'b0010: mode_valid = 1'b1;
         4'b0100: mode_valid = 1'b1;
         default: mode_valid = 1'b0;
      endcase
   endfunction

   // Handshake, read-credit and terminal-count decode.
   always_comb begin
      mode_ok_s    = mode_valid(mode);
      mode_beats_s = beats_for(mode);
      accept_s     = (state_r == IDLE) && start && mode_ok_s;
      pop_s        = (occ_r != 2'd0) && m_axis_tready;
      push_s       = rd_vld_r;
      // A word popped this cycle frees its slot in time for a read issued now.
      room_s       = (({1'b0, occ_r} + {2'b00, rd_vld_r}) - {2'b00, pop_s}) < 3'd2;
      rd_en_s      = (state_r == STREAM) && room_s;
      last_rd_s    = (rd_cnt_r == (beats_r - CW'(1)));
      last_beat_s  = (out_cnt_r == (beats_r - CW'(1)));
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_s = STREAM;
            else          state_s = IDLE;
         end
         STREAM: begin
            if (rd_en_s && last_rd_s) state_s = DRAIN;
            else                      state_s = STREAM;
         end
         DRAIN: begin
            if (pop_s && last_beat_s) state_s = IDLE;
            else                      state_s = DRAIN;
         end
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state_r <= IDLE;
      else        state_r <= state_s;
   end

   // Transfer length, read address counter and independent output beat counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         beats_r   <= {CW{1'b0}};
         rd_cnt_r  <= {CW{1'b0}};
         out_cnt_r <= {CW{1'b0}};
      end else if (accept_s) begin
         beats_r   <= mode_beats_s;
         rd_cnt_r  <= {CW{1'b0}};
         out_cnt_r <= {CW{1'b0}};
      end else begin
         if (rd_en_s) rd_cnt_r  <= rd_cnt_r + CW'(1);
         if (pop_s)   out_cnt_r <= out_cnt_r + CW'(1);
      end
   end

   // In-flight read tracking, FIFO occupancy/pointers and the completion pulse.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_vld_r <= 1'b0;
         occ_r    <= 2'd0;
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         rd_vld_r <= rd_en_s;
         occ_r    <= (occ_r + {1'b0, push_s}) - {1'b0, pop_s};
         if (push_s) wr_ptr_r <= ~wr_ptr_r;
         if (pop_s)  rd_ptr_r <= ~rd_ptr_r;
         done_r   <= (state_r == DRAIN) && pop_s && last_beat_s;
      end
   end

   // FIFO word storage; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) fifo_mem_r[wr_ptr_r] <= memReadData;
   end

   assign busy          = (state_r != IDLE);
   assign done          = done_r;
   assign memReadEn     = rd_en_s;
   assign memReadAddr   = rd_cnt_r[ADDR_WIDTH-1:0];
   assign m_axis_tvalid = (occ_r != 2'd0);
   assign m_axis_tdata  = fifo_mem_r[rd_ptr_r];
   assign m_axis_tlast  = (occ_r != 2'd0) && last_beat_s;

endmodule

// File: tb/tb_texture_streamer.sv
// Directed bench for texture_streamer: a 16-bit and a 64-bit instance, each fed by a RAM model
// holding RAM[i] = i.
module tb_texture_streamer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [3:0]  mode;
   logic        start16, start64, rdy16, rdy64;
   logic        busy16, done16, en16, v16, l16;
   logic [13:0] addr16;
   logic [15:0] rd16, d16;
   logic        busy64, done64, en64, v64, l64;
   logic [11:0] addr64;
   logic [63:0] rd64, d64;

   texture_streamer #(.STREAM_WIDTH(16), .SIZE(15)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .mode(mode), .busy(busy16), .done(done16),
      .memReadEn(en16), .memReadAddr(addr16), .memReadData(rd16), .m_axis_tvalid(v16),
      .m_axis_tready(rdy16), .m_axis_tlast(l16), .m_axis_tdata(d16));

   texture_streamer #(.STREAM_WIDTH(64), .SIZE(15)) dut64 (
      .clk(clk), .reset(reset), .start(start64), .mode(mode), .busy(busy64), .done(done64),
      .memReadEn(en64), .memReadAddr(addr64), .memReadData(rd64), .m_axis_tvalid(v64),
      .m_axis_tready(rdy64), .m_axis_tlast(l64), .m_axis_tdata(d64));

   always @(posedge clk) begin
      if (en16) rd16 <= 16'(addr16);
      if (en64) rd64 <= 64'(addr64);
   end

   int checks = 0;
   int errors = 0;
   int beats, bad_data, bad_last, last_cnt, done_cnt, busy_cyc, busy_in_done;
   int first_busy, first_vld, stable_bad, stall_reads, hs, abort_done;
   int inv_busy, inv_en, inv_vld;
   logic [63:0] first_d;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Runs ntr transfers of per beats each (restarting on done), gathering statistics.
   task automatic xfer(input bit sel, input logic [3:0] m, input int per, input int ntr,
                       input int rpct, input int stall, input int extra, input int budget);
      logic v, l, en, b, dn, rdy, st, pv, pl, pr;
      logic [63:0] d, pd;
      int idx;
      beats = 0; bad_data = 0; bad_last = 0; last_cnt = 0; done_cnt = 0; busy_cyc = 0;
      busy_in_done = 0; first_busy = -1; first_vld = -1; stable_bad = 0; stall_reads = 0;
      first_d = '1;
      pv = 1'b0; pl = 1'b0; pr = 1'b1; pd = 64'd0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         if (cyc < stall)     rdy = 1'b0;
         else if (rpct >= 100) rdy = 1'b1;
         else                 rdy = ($urandom_range(99) < rpct);
         if (sel) rdy64 = rdy; else rdy16 = rdy;
         #1;
         v  = sel ? v64 : v16;
         l  = sel ? l64 : l16;
         en = sel ? en64 : en16;
         b  = sel ? busy64 : busy16;
         dn = sel ? done64 : done16;
         d  = sel ? d64 : 64'(d16);
         if (b) begin
            busy_cyc++;
            if (first_busy < 0) first_busy = cyc;
         end
         if (v && first_vld < 0) first_vld = cyc;
         if (en && cyc < stall) stall_reads++;
         if (pv && !pr && (!v || d !== pd || l !== pl)) stable_bad++;
         pv = v; pd = d; pl = l; pr = rdy;
         if (v && rdy) begin
            idx = beats % per;
            if (beats == 0) first_d = d;
            if (d !== 64'(idx)) bad_data++;
            if (l !== (idx == per - 1)) bad_last++;
            if (l) last_cnt++;
            beats++;
         end
         if (dn) begin
            done_cnt++;
            if (b) busy_in_done++;
         end
         st = (cyc == 0) || (cyc == extra) || (dn && done_cnt < ntr);
         mode = (cyc == extra) ? 4'b0100 : m;
         if (sel) start64 = st; else start16 = st;
         @(posedge clk); #1;
         if (done_cnt == ntr) break;
      end
      start16 = 1'b0;
      start64 = 1'b0;
   endtask

   initial begin
      reset = 1'b0; mode = 4'b0000;
      start16 = 1'b0; start64 = 1'b0; rdy16 = 1'b0; rdy64 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy16), 64'd0);
      chk("rst_done", 64'(done16), 64'd0);
      chk("rst_rden", 64'(en16), 64'd0);
      chk("rst_addr", 64'(addr16), 64'd0);
      chk("rst_tvalid", 64'(v16), 64'd0);
      chk("rst_tlast", 64'(l16), 64'd0);
      chk("rst_busy64", 64'(busy64), 64'd0);
      chk("rst_tvalid64", 64'(v64), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // 32x32 at width 16, sink always ready
      xfer(1'b0, 4'b0001, 1024, 1, 100, 0, -1, 3000);
      chk("t1_beats", 64'(beats), 64'd1024);
      chk("t1_data", 64'(bad_data), 64'd0);
      chk("t1_tlast_pos", 64'(bad_last), 64'd0);
      chk("t1_tlast_cnt", 64'(last_cnt), 64'd1);
      chk("t1_done", 64'(done_cnt), 64'd1);
      chk("t1_busy_cycles", 64'(busy_cyc), 64'd1026);
      chk("t1_busy_in_done", 64'(busy_in_done), 64'd0);
      chk("t1_first_busy", 64'(first_busy), 64'd1);
      chk("t1_first_tvalid", 64'(first_vld), 64'd3);

      // 64x64 at width 64, random ready
      xfer(1'b1, 4'b0010, 1024, 1, 50, 0, -1, 8000);
      chk("t2_beats", 64'(beats), 64'd1024);
      chk("t2_data", 64'(bad_data), 64'd0);
      chk("t2_tlast_pos", 64'(bad_last), 64'd0);
      chk("t2_stable", 64'(stable_bad), 64'd0);
      chk("t2_done", 64'(done_cnt), 64'd1);

      // sink stalled for the first 20 cycles
      xfer(1'b0, 4'b0001, 1024, 1, 100, 20, -1, 3000);
      chk("t3_stall_reads", 64'(stall_reads), 64'd2);
      chk("t3_beats", 64'(beats), 64'd1024);
      chk("t3_data", 64'(bad_data), 64'd0);
      chk("t3_stable", 64'(stable_bad), 64'd0);
      chk("t3_done", 64'(done_cnt), 64'd1);

      // invalid mode is ignored
      inv_busy = 0; inv_en = 0; inv_vld = 0;
      mode = 4'b0011; start16 = 1'b1; rdy16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0;
      repeat (10) begin
         if (busy16) inv_busy++;
         if (en16) inv_en++;
         if (v16) inv_vld++;
         @(posedge clk); #1;
      end
      chk("t4_busy", 64'(inv_busy), 64'd0);
      chk("t4_rden", 64'(inv_en), 64'd0);
      chk("t4_tvalid", 64'(inv_vld), 64'd0);

      // start with mode 0100 while busy is ignored
      xfer(1'b0, 4'b0001, 1024, 1, 100, 0, 10, 3000);
      chk("t5_beats", 64'(beats), 64'd1024);
      chk("t5_tlast_cnt", 64'(last_cnt), 64'd1);
      chk("t5_data", 64'(bad_data), 64'd0);
      chk("t5_done", 64'(done_cnt), 64'd1);

      // reset after beat 500, then a fresh transfer
      mode = 4'b0001; rdy16 = 1'b1; start16 = 1'b1; hs = 0; abort_done = 0;
      for (int c = 0; c < 3000 && hs < 500; c++) begin
         #1;
         if (v16) hs++;
         if (done16) abort_done++;
         @(posedge clk); #1;
         start16 = 1'b0;
      end
      chk("t6_beats_before_reset", 64'(hs), 64'd500);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("t6_busy_after_reset", 64'(busy16), 64'd0);
      chk("t6_tvalid_after_reset", 64'(v16), 64'd0);
      chk("t6_rden_after_reset", 64'(en16), 64'd0);
      repeat (3) begin
         if (done16) abort_done++;
         @(posedge clk); #1;
      end
      chk("t6_no_abort_done", 64'(abort_done), 64'd0);
      xfer(1'b0, 4'b0001, 1024, 1, 100, 0, -1, 3000);
      chk("t6_first_data", first_d, 64'd0);
      chk("t6_beats", 64'(beats), 64'd1024);
      chk("t6_data", 64'(bad_data), 64'd0);
      chk("t6_done", 64'(done_cnt), 64'd1);

      // start in the done cycle: back-to-back transfers
      xfer(1'b0, 4'b0001, 1024, 2, 100, 0, -1, 5000);
      chk("t7_beats", 64'(beats), 64'd2048);
      chk("t7_done", 64'(done_cnt), 64'd2);
      chk("t7_tlast_cnt", 64'(last_cnt), 64'd2);
      chk("t7_tlast_pos", 64'(bad_last), 64'd0);
      chk("t7_data", 64'(bad_data), 64'd0);
      chk("t7_busy_cycles", 64'(busy_cyc), 64'd2052);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
